// File: rtl/uart_core.sv
// UART transmitter/receiver pair with load/unload handshakes.
// TX runs on a 1x baud tick; RX oversamples on a 16x tick and samples mid-bit.
module uart_core #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_tick,
    input  logic       rx_tick,
    input  logic       ld_tx_req,
    output logic       ld_tx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_out,
    output logic       tx_empty,
    input  logic       uld_rx_req,
    output logic       uld_rx_ack,
    output logic [7:0] rx_data,
    input  logic       rx_enable,
    input  logic       rx_in,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t  r_tx_state, w_tx_state_next;
    logic [2:0] r_tx_bit_cnt, w_tx_bit_cnt_next;
    logic       r_tx_stop_cnt, w_tx_stop_cnt_next;
    logic       r_tx_out, w_tx_out_next;
    logic       w_tx_done;
    logic [7:0] r_tx_hold;
    logic       r_tx_empty;
    logic       r_ld_tx_ack;
    logic       w_tx_load;

    rx_state_t  r_rx_state, w_rx_state_next;
    logic [3:0] r_rx_tick_cnt, w_rx_tick_cnt_next;
    logic [2:0] r_rx_bit_cnt, w_rx_bit_cnt_next;
    logic [7:0] r_rx_shift, w_rx_shift_next;
    logic       w_rx_done;
    logic       w_rx_ferr;
    logic       r_rx_sync1, r_rx_sync2;
    logic [7:0] r_rx_hold;
    logic       r_rx_empty;
    logic       r_rx_ferr_pend, r_rx_ovr_pend;
    logic       r_uld_rx_ack;
    logic [7:0] r_rx_data;
    logic       r_rx_frame_err, r_rx_overrun;
    logic       w_rx_unload;

    assign w_tx_load   = ld_tx_req && !r_ld_tx_ack && r_tx_empty;
    assign w_rx_unload = uld_rx_req && !r_uld_rx_ack && !r_rx_empty;

    // The holding register doubles as the shift source: it cannot be reloaded
    // until the frame ends because tx_empty stays low throughout.
    always_comb begin
        w_tx_state_next    = r_tx_state;
        w_tx_bit_cnt_next  = r_tx_bit_cnt;
        w_tx_stop_cnt_next = r_tx_stop_cnt;
        w_tx_out_next      = r_tx_out;
        w_tx_done          = 1'b0;
        if (tx_tick) begin
            unique case (r_tx_state)
                TX_IDLE: begin
                    if (!r_tx_empty && tx_enable) begin
                        w_tx_state_next = TX_START;
                        w_tx_out_next   = 1'b0;
                    end
                end
                TX_START: begin
                    w_tx_state_next   = TX_DATA;
                    w_tx_bit_cnt_next = 3'd0;
                    w_tx_out_next     = r_tx_hold[0];
                end
                TX_DATA: begin
                    if (r_tx_bit_cnt == 3'd7) begin
                        w_tx_state_next    = TX_STOP;
                        w_tx_stop_cnt_next = 1'b0;
                        w_tx_out_next      = 1'b1;
                    end else begin
                        w_tx_bit_cnt_next = r_tx_bit_cnt + 3'd1;
                        w_tx_out_next     = r_tx_hold[r_tx_bit_cnt + 3'd1];
                    end
                end
                TX_STOP: begin
                    if (r_tx_stop_cnt == STOP_LAST) begin
                        w_tx_state_next = TX_IDLE;
                        w_tx_done       = 1'b1;
                    end else begin
                        w_tx_stop_cnt_next = 1'b1;
                    end
                end
                default: w_tx_state_next = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state    <= TX_IDLE;
            r_tx_bit_cnt  <= 3'd0;
            r_tx_stop_cnt <= 1'b0;
            r_tx_out      <= 1'b1;
        end else begin
            r_tx_state    <= w_tx_state_next;
            r_tx_bit_cnt  <= w_tx_bit_cnt_next;
            r_tx_stop_cnt <= w_tx_stop_cnt_next;
            r_tx_out      <= w_tx_out_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_hold   <= 8'h00;
            r_tx_empty  <= 1'b1;
            r_ld_tx_ack <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_hold   <= tx_data;
            r_tx_empty  <= 1'b0;
            r_ld_tx_ack <= 1'b1;
        end else begin
            if (!ld_tx_req) r_ld_tx_ack <= 1'b0;
            if (w_tx_done)  r_tx_empty  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
        end else begin
            r_rx_sync1 <= rx_in;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    // Start is confirmed 8 ticks after the falling edge, which centres every
    // later 16-tick sample in its bit.
    always_comb begin
        w_rx_state_next    = r_rx_state;
        w_rx_tick_cnt_next = r_rx_tick_cnt;
        w_rx_bit_cnt_next  = r_rx_bit_cnt;
        w_rx_shift_next    = r_rx_shift;
        w_rx_done          = 1'b0;
        w_rx_ferr          = 1'b0;
        if (rx_tick) begin
            unique case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync2 && rx_enable) begin
                        w_rx_state_next    = RX_START;
                        w_rx_tick_cnt_next = 4'd0;
                    end
                end
                RX_START: begin
                    if (r_rx_tick_cnt == 4'd7) begin
                        w_rx_tick_cnt_next = 4'd0;
                        w_rx_bit_cnt_next  = 3'd0;
                        w_rx_state_next    = r_rx_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        w_rx_tick_cnt_next = r_rx_tick_cnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_tick_cnt == 4'd15) begin
                        w_rx_tick_cnt_next = 4'd0;
                        w_rx_shift_next    = {r_rx_sync2, r_rx_shift[7:1]};
                        if (r_rx_bit_cnt == 3'd7) w_rx_state_next = RX_STOP;
                        else                      w_rx_bit_cnt_next = r_rx_bit_cnt + 3'd1;
                    end else begin
                        w_rx_tick_cnt_next = r_rx_tick_cnt + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_tick_cnt == 4'd15) begin
                        w_rx_state_next    = RX_IDLE;
                        w_rx_tick_cnt_next = 4'd0;
                        w_rx_done          = 1'b1;
                        w_rx_ferr          = !r_rx_sync2;
                    end else begin
                        w_rx_tick_cnt_next = r_rx_tick_cnt + 4'd1;
                    end
                end
                default: w_rx_state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state    <= RX_IDLE;
            r_rx_tick_cnt <= 4'd0;
            r_rx_bit_cnt  <= 3'd0;
            r_rx_shift    <= 8'h00;
        end else begin
            r_rx_state    <= w_rx_state_next;
            r_rx_tick_cnt <= w_rx_tick_cnt_next;
            r_rx_bit_cnt  <= w_rx_bit_cnt_next;
            r_rx_shift    <= w_rx_shift_next;
        end
    end

    // A completion coinciding with an unload refills holding without overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_hold      <= 8'h00;
            r_rx_empty     <= 1'b1;
            r_rx_ferr_pend <= 1'b0;
            r_rx_ovr_pend  <= 1'b0;
            r_uld_rx_ack   <= 1'b0;
            r_rx_data      <= 8'h00;
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= 1'b0;
        end else begin
            if (w_rx_unload) begin
                r_rx_data      <= r_rx_hold;
                r_rx_frame_err <= r_rx_ferr_pend;
                r_rx_overrun   <= r_rx_ovr_pend;
                r_uld_rx_ack   <= 1'b1;
            end else if (!uld_rx_req) begin
                r_uld_rx_ack   <= 1'b0;
            end
            if (w_rx_done) begin
                r_rx_hold      <= r_rx_shift;
                r_rx_empty     <= 1'b0;
                r_rx_ferr_pend <= w_rx_ferr;
                r_rx_ovr_pend  <= !r_rx_empty && !w_rx_unload;
            end else if (w_rx_unload) begin
                r_rx_empty     <= 1'b1;
                r_rx_ferr_pend <= 1'b0;
                r_rx_ovr_pend  <= 1'b0;
            end
        end
    end

    assign ld_tx_ack    = r_ld_tx_ack;
    assign tx_out       = r_tx_out;
    assign tx_empty     = r_tx_empty;
    assign uld_rx_ack   = r_uld_rx_ack;
    assign rx_data      = r_rx_data;
    assign rx_empty     = r_rx_empty;
    assign rx_frame_err = r_rx_frame_err;
    assign rx_overrun   = r_rx_overrun;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: directed TX/RX traffic, expectations queued,
// independent monitors decode the serial line and the unload handshake.
module tb_uart_core;

    localparam int TXDIV = 16;
    localparam int RXBIT = 32;

    logic       clk, reset, tx_tick, rx_tick;
    logic       ld_tx_req, ld_tx_ack, tx_enable, tx_out, tx_empty;
    logic [7:0] tx_data, rx_data;
    logic       uld_rx_req, uld_rx_ack, rx_enable, rx_in, rx_empty;
    logic       rx_frame_err, rx_overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tx_q[$];
    logic [9:0] rx_q[$];   // {overrun, frame_err, data}

    uart_core #(.STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .tx_tick(tx_tick), .rx_tick(rx_tick),
        .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack), .tx_data(tx_data),
        .tx_enable(tx_enable), .tx_out(tx_out), .tx_empty(tx_empty),
        .uld_rx_req(uld_rx_req), .uld_rx_ack(uld_rx_ack), .rx_data(rx_data),
        .rx_enable(rx_enable), .rx_in(rx_in), .rx_empty(rx_empty),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        tx_tick = 1'b0;
        forever begin
            repeat (TXDIV - 1) @(negedge clk);
            tx_tick = 1'b1;
            @(negedge clk);
            tx_tick = 1'b0;
        end
    end

    initial begin
        rx_tick = 1'b0;
        forever begin
            @(negedge clk);
            rx_tick = ~rx_tick;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decodes each transmitted frame at mid-bit and compares with the queue.
    initial begin : tx_monitor
        logic       prev;
        logic [9:0] bits;
        logic       aborted;
        logic       pre_empty;
        logic [7:0] exp_b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && prev === 1'b1 && tx_out === 1'b0) begin
                aborted   = 1'b0;
                bits      = '0;
                pre_empty = 1'b1;
                for (int c = 1; c <= 10 * TXDIV && !aborted; c++) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                    else begin
                        if (c % TXDIV == TXDIV / 2) bits[c / TXDIV] = tx_out;
                        if (c == 10 * TXDIV - 1)    pre_empty = tx_empty;
                    end
                end
                if (!aborted) begin
                    check("tx_empty_before_end", pre_empty, 1'b0);
                    check("tx_empty_after_frame", tx_empty, 1'b1);
                    check("tx_start_bit", bits[0], 1'b0);
                    check("tx_stop_bit", bits[9], 1'b1);
                    check("tx_q_nonempty", tx_q.size() != 0, 1'b1);
                    if (tx_q.size() != 0) begin
                        exp_b = tx_q.pop_front();
                        check("tx_byte", bits[8:1], exp_b);
                        $display("tx frame: byte %02h expected %02h", bits[8:1], exp_b);
                    end
                end
            end
            prev = tx_out;
        end
    end

    // Compares the unloaded byte and status on every rising uld_rx_ack.
    initial begin : rx_monitor
        logic       prev_ack;
        logic [9:0] exp_r;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (uld_rx_ack === 1'b1 && prev_ack === 1'b0) begin
                check("rx_q_nonempty", rx_q.size() != 0, 1'b1);
                if (rx_q.size() != 0) begin
                    exp_r = rx_q.pop_front();
                    check("rx_data", rx_data, exp_r[7:0]);
                    check("rx_frame_err", rx_frame_err, exp_r[8]);
                    check("rx_overrun", rx_overrun, exp_r[9]);
                    check("rx_empty_after_unload", rx_empty, 1'b1);
                    $display("rx unload: data %02h ferr %0b ovr %0b expected %02h %0b %0b",
                             rx_data, rx_frame_err, rx_overrun, exp_r[7:0], exp_r[8], exp_r[9]);
                end
            end
            prev_ack = uld_rx_ack;
        end
    end

    task automatic ld_tx(input logic [7:0] d);
        int t;
        tx_data   = d;
        ld_tx_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ld_tx_ack && t < 50);
        check("ld_ack_seen", ld_tx_ack, 1'b1);
        check("tx_empty_after_load", tx_empty, 1'b0);
        @(negedge clk);
        check("ld_ack_held", ld_tx_ack, 1'b1);
        ld_tx_req = 1'b0;
        @(negedge clk);
        check("ld_ack_drop", ld_tx_ack, 1'b0);
    endtask

    task automatic wait_tx_empty(input int limit);
        int t;
        t = 0;
        while (!tx_empty && t < limit) begin @(negedge clk); t++; end
        check("tx_empty_wait", tx_empty, 1'b1);
    endtask

    task automatic wait_tx_low(input int limit);
        int t;
        t = 0;
        while (tx_out && t < limit) begin @(negedge clk); t++; end
        check("tx_start_wait", tx_out, 1'b0);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_in = frame[k];
            repeat (RXBIT) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (2 * RXBIT) @(negedge clk);
    endtask

    task automatic do_unload();
        int t;
        uld_rx_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!uld_rx_ack && t < 50);
        check("uld_ack_seen", uld_rx_ack, 1'b1);
        @(negedge clk);
        check("uld_ack_held", uld_rx_ack, 1'b1);
        uld_rx_req = 1'b0;
        @(negedge clk);
        check("uld_ack_drop", uld_rx_ack, 1'b0);
    endtask

    initial begin : main
        reset      = 1'b1;
        ld_tx_req  = 1'b0;
        tx_data    = 8'h00;
        tx_enable  = 1'b1;
        uld_rx_req = 1'b0;
        rx_enable  = 1'b1;
        rx_in      = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_tx_empty", tx_empty, 1'b1);
        check("rst_ld_ack", ld_tx_ack, 1'b0);
        check("rst_uld_ack", uld_rx_ack, 1'b0);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_frame_err", rx_frame_err, 1'b0);
        check("rst_overrun", rx_overrun, 1'b0);

        // Transmit 0x55
        tx_q.push_back(8'h55);
        ld_tx(8'h55);
        wait_tx_empty(250);
        repeat (4) @(negedge clk);

        // Receive 0xA3 with a valid stop bit
        rx_q.push_back({1'b0, 1'b0, 8'hA3});
        send_rx(8'hA3, 1'b1);
        check("rx_empty_after_A3", rx_empty, 1'b0);
        do_unload();

        // Two frames without unload: second overwrites, overrun reported
        rx_q.push_back({1'b1, 1'b0, 8'h22});
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check("rx_empty_after_22", rx_empty, 1'b0);
        do_unload();

        // Bad stop bit
        rx_q.push_back({1'b0, 1'b1, 8'h7E});
        send_rx(8'h7E, 1'b0);
        check("rx_empty_after_7E", rx_empty, 1'b0);
        do_unload();

        // 4-tick low glitch must not start a frame
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_rx_empty", rx_empty, 1'b1);
        check("glitch_rx_data_kept", rx_data, 8'h7E);

        // Unload request with nothing held is ignored
        uld_rx_req = 1'b1;
        repeat (5) @(negedge clk);
        check("uld_empty_no_ack", uld_rx_ack, 1'b0);
        check("uld_empty_data_kept", rx_data, 8'h7E);
        uld_rx_req = 1'b0;
        @(negedge clk);

        // Transmit gated by tx_enable, then a load attempt mid-frame
        tx_enable = 1'b0;
        tx_q.push_back(8'hC3);
        ld_tx(8'hC3);
        repeat (3 * TXDIV) @(negedge clk);
        check("gated_tx_out", tx_out, 1'b1);
        check("gated_tx_empty", tx_empty, 1'b0);
        tx_enable = 1'b1;
        wait_tx_low(40);
        repeat (2 * TXDIV) @(negedge clk);
        tx_data   = 8'h3C;
        ld_tx_req = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_ld_no_ack", ld_tx_ack, 1'b0);
        check("busy_tx_empty", tx_empty, 1'b0);
        ld_tx_req = 1'b0;
        wait_tx_empty(250);
        repeat (4) @(negedge clk);

        // Reset in the middle of the data bits aborts the frame
        ld_tx(8'h0F);
        wait_tx_low(40);
        repeat (3 * TXDIV) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx_out", tx_out, 1'b1);
        check("midrst_tx_empty", tx_empty, 1'b1);
        check("midrst_ld_ack", ld_tx_ack, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * TXDIV) @(negedge clk);
        check("post_rst_tx_idle", tx_out, 1'b1);

        check("tx_q_drained", tx_q.size(), 0);
        check("rx_q_drained", rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
